// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: op codes and FSM state encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_pkg;

  // Op codes understood by the preprocessor plus adder/logic unit
  localparam logic [2:0] OP_PASS = 3'b000;  // A
  localparam logic [2:0] OP_NEG  = 3'b001;  // 0 + ~A + 1
  localparam logic [2:0] OP_ADD  = 3'b010;  // A + B
  localparam logic [2:0] OP_INC  = 3'b011;  // A + 1
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_NOT  = 3'b111;

  // Scheduler FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant from valids and last-served pointer.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own ready conditions.
module rr_arb2 (
  input  logic [1:0] vld,
  input  logic       ptr,   // id of the requester served last
  output logic [1:0] gnt
);

  // Contention goes to the requester not served last; otherwise the lone valid wins
  always_comb begin
    gnt = vld;
    if (vld == 2'b11) begin
      gnt = ptr ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Two-requester round-robin scheduler for the shared ALU datapath.
// Latency: handshake at T -> operands driven T+1..T+ALU_LAT -> rsp_valid from T+ALU_LAT+1.
// Backpressure: one op in flight; requests are not accepted until the response is taken.
module alu_sched
  import alu_pkg::*;
#(
  parameter int W       = 4,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [2:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  output logic         alu_cin,
  input  logic [W-1:0] alu_y,
  input  logic         alu_cout,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_y,
  output logic         rsp_cout,
  output logic         busy
);

  if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_lat_chk
    $error("alu_sched: ALU_LAT must be within 1..15");
  end

  logic [1:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         ptr_q, ptr_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [2:0]   op_q, op_d;
  logic         id_q, id_d;
  logic [W-1:0] y_q, y_d;
  logic         cout_q, cout_d;
  logic [1:0]   gnt;
  logic         idle;

  rr_arb2 u_arb (
    .vld (({req1_valid, req0_valid})),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  assign idle       = (state_q == S_IDLE);
  assign req0_ready = idle & gnt[0];
  assign req1_ready = idle & gnt[1];

  // The operand registers only change on a handshake, which always enters ISSUE,
  // so driving the datapath straight from them holds the last issued values elsewhere.
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_op  = op_q;
  assign alu_cin = (op_q == OP_NEG);

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_y     = y_q;
  assign rsp_cout  = cout_q;
  assign busy      = !idle;

  // Next-state: accept in IDLE, count down the datapath latency, hold the response
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    id_d    = id_q;
    y_d     = y_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (gnt != 2'b00) begin
          a_d     = gnt[1] ? req1_a  : req0_a;
          b_d     = gnt[1] ? req1_b  : req0_b;
          op_d    = gnt[1] ? req1_op : req0_op;
          id_d    = gnt[1];
          cnt_d   = 4'(ALU_LAT - 1);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cnt_q == 4'd0) begin
          y_d     = alu_y;
          cout_d  = alu_cout;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          ptr_d   = id_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; pointer resets to 1 so req0 wins the first contention
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ptr_q   <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_PASS;
      id_q    <= 1'b0;
      y_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: directed steps plus randomized ops against an arithmetic reference.
// Latency: two instances, ALU_LAT = 1 and ALU_LAT = 3, each with a modelled datapath.
// Backpressure: response stalls of several cycles are exercised.
module tb_alu_sched;
  import alu_pkg::*;

  localparam int W = 4;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ALU_LAT = 1 instance
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] alu_a, alu_b, alu_y, rsp_y;
  logic [2:0]   alu_op;
  logic         alu_cin, alu_cout, rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;

  // ALU_LAT = 3 instance
  logic         l3_req0_valid, l3_req1_valid, l3_req0_ready, l3_req1_ready;
  logic [W-1:0] l3_req0_a, l3_req0_b, l3_req1_a, l3_req1_b;
  logic [2:0]   l3_req0_op, l3_req1_op;
  logic [W-1:0] l3_alu_a, l3_alu_b, l3_alu_y, l3_rsp_y;
  logic [2:0]   l3_alu_op;
  logic         l3_alu_cin, l3_alu_cout, l3_rsp_valid, l3_rsp_ready, l3_rsp_id, l3_rsp_cout, l3_busy;

  alu_sched #(.W(W), .ALU_LAT(LAT1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_cout(rsp_cout),
    .busy(busy)
  );

  alu_sched #(.W(W), .ALU_LAT(3)) dut_l3 (
    .clk(clk), .rst(rst),
    .req0_valid(l3_req0_valid), .req0_ready(l3_req0_ready), .req0_a(l3_req0_a), .req0_b(l3_req0_b), .req0_op(l3_req0_op),
    .req1_valid(l3_req1_valid), .req1_ready(l3_req1_ready), .req1_a(l3_req1_a), .req1_b(l3_req1_b), .req1_op(l3_req1_op),
    .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_op(l3_alu_op), .alu_cin(l3_alu_cin),
    .alu_y(l3_alu_y), .alu_cout(l3_alu_cout),
    .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready), .rsp_id(l3_rsp_id), .rsp_y(l3_rsp_y), .rsp_cout(l3_rsp_cout),
    .busy(l3_busy)
  );

  // Datapath model: preprocessor chooses adder inputs, then adder or logic unit
  function automatic logic [4:0] datapath(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op, input logic cin);
    logic [3:0] x, y;
    x = a;
    y = b;
    case (op)
      OP_PASS: y = 4'd0;
      OP_NEG:  begin x = 4'd0; y = ~a; end
      OP_INC:  y = 4'd1;
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_NOT:  return {1'b0, ~a};
      default: ;
    endcase
    return {1'b0, x} + {1'b0, y} + {4'd0, cin};
  endfunction

  // Expected {cout, y} straight from the op's arithmetic meaning
  function automatic logic [4:0] expect_res(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int s;
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    case (op)
      OP_PASS: s = ia;
      OP_NEG:  s = 16 - ia;          // -A; carry out only when A is zero
      OP_ADD:  s = ia + ib;
      OP_INC:  s = ia + 1;
      OP_AND:  s = int'(a & b);
      OP_OR:   s = int'(a | b);
      OP_XOR:  s = int'(a ^ b);
      default: s = 15 - ia;          // NOT A
    endcase
    return 5'(s);
  endfunction

  assign {alu_cout, alu_y} = datapath(alu_a, alu_b, alu_op, alu_cin);

  // Three-cycle datapath: two register stages after the combinational result
  logic [4:0] l3_p1, l3_p2;
  always @(posedge clk) begin
    l3_p1 <= datapath(l3_alu_a, l3_alu_b, l3_alu_op, l3_alu_cin);
    l3_p2 <= l3_p1;
  end
  assign {l3_alu_cout, l3_alu_y} = l3_p2;

  int n_total = 0;
  int n_pass  = 0;
  int last_served = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One complete transaction on the ALU_LAT = 1 instance, with 'hold' stalled RESP cycles
  task automatic txn(input logic v0, input logic v1,
                     input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] o0,
                     input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] o1,
                     input int hold);
    int win;
    logic [3:0] ea, eb;
    logic [2:0] eo;
    logic [4:0] er;
    win = (v0 && v1) ? ((last_served == 1) ? 0 : 1) : (v0 ? 0 : 1);
    ea = (win == 0) ? a0 : a1;
    eb = (win == 0) ? b0 : b1;
    eo = (win == 0) ? o0 : o1;
    er = expect_res(eo, ea, eb);
    @(posedge clk); #1;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("grant_ready0", req0_ready, win == 0);
    chk("grant_ready1", req1_ready, win == 1);
    @(posedge clk); #1;
    // Drop both requests and scramble operands: the DUT must use its latched copy
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 4'($urandom); req1_a = 4'($urandom);
    req0_op = 3'($urandom); req1_op = 3'($urandom);
    for (int i = 0; i < LAT1; i++) begin
      @(negedge clk);
      chk("issue_op", alu_op, eo);
      chk("issue_a", alu_a, ea);
      chk("issue_cin", alu_cin, eo == OP_NEG);
      chk("issue_busy", busy, 1);
      chk("issue_rsp_valid", rsp_valid, 0);
      chk("issue_readies", {req1_ready, req0_ready}, 0);
      @(posedge clk); #1;
    end
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_y", rsp_y, er[3:0]);
      chk("rsp_cout", rsp_cout, er[4]);
      chk("rsp_id", rsp_id, win);
      chk("rsp_busy", busy, 1);
      chk("rsp_readies", {req1_ready, req0_ready}, 0);
      if (i == hold) rsp_ready = 1'b1;
      else if (i == 0) begin req0_valid = 1'b1; req1_valid = 1'b1; end  // must be ignored while stalled
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    last_served = win;
    @(negedge clk);
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_busy", busy, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_served = 1;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    l3_req0_valid = 0; l3_req1_valid = 0; l3_rsp_ready = 0;
    l3_req0_a = 0; l3_req0_b = 0; l3_req0_op = 0; l3_req1_a = 0; l3_req1_b = 0; l3_req1_op = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_y", rsp_y, 0);
    chk("reset_rsp_cout", rsp_cout, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_b", alu_b, 0);
    chk("reset_alu_op", alu_op, 0);
    chk("reset_alu_cin", alu_cin, 0);
    chk("reset_busy", busy, 0);
    chk("reset_l3_busy", l3_busy, 0);
    rst = 1'b0;

    // Directed ops from the plan
    txn(1, 0, 4'b1010, 4'b0111, OP_ADD, 4'd0, 4'd0, OP_PASS, 0);
    txn(0, 1, 4'd0, 4'd0, OP_PASS, 4'b0011, 4'b0000, OP_NEG, 0);

    // Contention right after reset: req0 first, then req1
    do_reset();
    txn(1, 1, 4'd5, 4'd6, OP_OR, 4'd9, 4'd3, OP_XOR, 0);
    txn(1, 1, 4'd5, 4'd6, OP_OR, 4'd9, 4'd3, OP_XOR, 0);

    // Stalled response for five cycles
    txn(0, 1, 4'd0, 4'd0, OP_PASS, 4'b1100, 4'b1010, OP_AND, 5);

    // Reset while ISSUE: nothing returned, pointer back to 1
    txn(1, 0, 4'd7, 4'd0, OP_NOT, 4'd0, 4'd0, OP_PASS, 0);   // req0 served last
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = 4'd4; req1_b = 4'd4; req1_op = OP_ADD;
    @(negedge clk);
    chk("pre_rst_ready1", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    last_served = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_rsp_y", rsp_y, 0);
    end
    txn(1, 1, 4'd1, 4'd2, OP_ADD, 4'd3, 4'd4, OP_ADD, 0);

    // Randomized ops, including contention and stalls
    for (int k = 0; k < 40; k++) begin
      logic v0, v1;
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      txn(v0, v1, 4'($urandom), 4'($urandom), 3'($urandom),
          4'($urandom), 4'($urandom), 3'($urandom), int'($urandom_range(0, 2)));
    end

    // ALU_LAT = 3: INC 1111 gives 0000 with carry, response at T+4
    @(posedge clk); #1;
    l3_req0_valid = 1'b1; l3_req0_a = 4'b1111; l3_req0_b = 4'($urandom); l3_req0_op = OP_INC;
    @(negedge clk);
    chk("l3_ready0", l3_req0_ready, 1);
    @(posedge clk); #1;
    l3_req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("l3_issue_rsp_valid", l3_rsp_valid, 0);
      chk("l3_issue_busy", l3_busy, 1);
      chk("l3_issue_op", l3_alu_op, OP_INC);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("l3_rsp_valid", l3_rsp_valid, 1);
    chk("l3_rsp_y", l3_rsp_y, 4'b0000);
    chk("l3_rsp_cout", l3_rsp_cout, 1);
    chk("l3_rsp_id", l3_rsp_id, 0);
    l3_rsp_ready = 1'b1;
    @(posedge clk); #1;
    l3_rsp_ready = 1'b0;
    @(negedge clk);
    chk("l3_done_rsp_valid", l3_rsp_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
